hash_table_master: RTL and testbench
====================================

# hash_table_master

Initiator for the hash table op port. It accepts commands on a valid/ready channel and drives one insert, delete or search at a time into the hash table. It holds the operands stable until the table asserts op_done, then returns value, status and collision count on a valid/ready response channel. It sits between a host or CPU-side command source and a hash_table instance.

## Interface
Parameters:
- KEY_WIDTH, 32, key width; must match the attached hash table.
- VALUE_WIDTH, 32, value width.
- CNT_WIDTH, 2, width of the collision_count returned by the table.
- TIMEOUT_CYCLES, 16, WAIT cycles before abort; range 1..65535. Used only when the timeout feature is compiled in.

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command.
- cmd_op  in  2  00 insert, 01 delete, 10 search, 11 illegal.
- cmd_key  in  KEY_WIDTH  command key.
- cmd_value  in  VALUE_WIDTH  insert value; ignored for delete and search.
- op_en  out  1  one-cycle start pulse to the table.
- op_sel  out  2  registered opcode.
- op_key  out  KEY_WIDTH  registered key.
- op_value  out  VALUE_WIDTH  registered value.
- op_value_out  in  VALUE_WIDTH  table search result.
- op_done  in  1  table completion.
- op_error  in  1  table error (FULL or KEY_NOT_FOUND), qualified by op_done.
- op_collision_count  in  CNT_WIDTH  table chain count, qualified by op_done.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_status  out  2  00 OK, 01 TABLE_ERROR, 10 TIMEOUT, 11 BAD_OP.
- rsp_value  out  VALUE_WIDTH  captured op_value_out; 0 unless the op is a search with OK status.
- rsp_collision_count  out  CNT_WIDTH  captured op_collision_count; 0 for TIMEOUT and BAD_OP.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_op, cmd_key and cmd_value into op_sel, op_key and op_value.
  - Legal op: go to ISSUE.
  - cmd_op=11: go to RESP with rsp_status=11; the table is never touched.
- ISSUE: op_en=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - op_en=0; op_sel, op_key and op_value stay stable.
  - On op_done=1, capture op_error, op_value_out and op_collision_count.
  - rsp_status = op_error ? 01 : 00.
  - Go to RESP.
- RESP:
  - rsp_valid=1; all rsp_* outputs stay stable until rsp_valid && rsp_ready.
  - After the handshake, go to IDLE.
- op_done arriving in the ISSUE cycle is sampled and handled as in WAIT; the FSM goes straight to RESP.
- op_done outside ISSUE and WAIT is ignored.
- Only one outstanding table operation at a time; no pipelining.
- op_sel, op_key and op_value hold their last values in IDLE until the next accept.

## Timing
- Reset values: cmd_ready=0 while rst is asserted, 1 in the first cycle after deassertion (FSM in IDLE). All other outputs are 0 and the FSM is in IDLE.
- Reset mid-operation aborts immediately: op_en drops and no response is produced for the in-flight command.
- Command accept to op_en: 1 cycle (accept edge, then ISSUE cycle).
- op_done seen at edge N: rsp_valid is high from cycle N+1.
- Best-case accept to rsp_valid: 2 cycles, with op_done asserted in the ISSUE cycle.
- BAD_OP: rsp_valid is high the cycle after accept.
- A new command is accepted no earlier than the cycle after the response handshake. There is no same-cycle back-to-back.
- rsp_ready held high while in RESP: the response lasts exactly 1 cycle.

## Configuration
- Macro HT_MASTER_TIMEOUT_EN.
- Defined:
  - A 16-bit timeout counter clears on entry to ISSUE and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES with op_done still low, the FSM goes to RESP with rsp_status=10, rsp_value=0 and rsp_collision_count=0.
  - If op_done and timeout land in the same cycle, op_done wins.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - Status 10 is never produced.
  - TIMEOUT_CYCLES is unused.

## Structure
- Package hash_table_master_pkg holds:
  - the opcode localparams (OP_INSERT, OP_DELETE, OP_SEARCH);
  - the rsp_status enum (ST_OK, ST_TABLE_ERROR, ST_TIMEOUT, ST_BAD_OP);
  - the FSM state enum.
- One sub-module: hash_table_master_timer, a loadable 16-bit up-counter with an expiry flag. It is instantiated only under HT_MASTER_TIMEOUT_EN.

## Test plan
- Insert key 0x05 value 0xAA; the table returns op_done with op_error=0, collision_count=1, 3 cycles after op_en. Expect: op_en high exactly one cycle; op_key=0x05 stable until op_done; rsp_status=00; rsp_collision_count=1.
- Search key 0x05; the table returns op_done with value 0xAA. Expect: rsp_value=0xAA, rsp_status=00; rsp_ready held low 4 cycles keeps the response stable.
- Delete key 0x09; the table returns op_done with op_error=1. Expect: rsp_status=01 and rsp_value=0.
- cmd_op=11. Expect: no op_en; rsp_valid the next cycle with rsp_status=11.
- With HT_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, op_done never arrives. Expect: rsp_status=10 after 4 WAIT cycles. Repeat with op_done on the 4th cycle. Expect: rsp_status=00.
- rst asserted during WAIT. Expect: op_en=0, rsp_valid=0 and busy=0 while rst is asserted, and cmd_ready=1 in the first cycle after deassertion. A late op_done after reset is ignored.

Source files
------------

// File: rtl/hash_table_master_pkg.sv
// hash_table_master_pkg
// Shared opcodes, response status codes and FSM state encoding for
// hash_table_master and its timer.
package hash_table_master_pkg;

    localparam logic [1:0] OP_INSERT  = 2'b00;
    localparam logic [1:0] OP_DELETE  = 2'b01;
    localparam logic [1:0] OP_SEARCH  = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_OK          = 2'b00,
        ST_TABLE_ERROR = 2'b01,
        ST_TIMEOUT     = 2'b10,
        ST_BAD_OP      = 2'b11
    } rsp_status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_e;

    function automatic logic is_legal_op(input logic [1:0] op);
        return op != OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/hash_table_master_timer.sv
// hash_table_master_timer
// Loadable 16-bit up-counter used as the WAIT-state watchdog.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   load      clear the count to zero (has priority over inc)
//   inc       count up by one
//   limit     expiry threshold (1..65535)
//   count     current count
//   expired   high in the cycle whose increment brings count up to limit
module hash_table_master_timer
    import hash_table_master_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        inc,
    input  logic [15:0] limit,
    output logic [15:0] count,
    output logic        expired
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= 16'd0;
        else if (load)
            count <= 16'd0;
        else if (inc)
            count <= count + 16'd1;
    end

    // Count is k-1 during the k-th counted cycle, so the limit is hit
    // in the cycle that would complete the limit-th increment.
    assign expired = (count + 16'd1) == limit;

endmodule

// File: rtl/hash_table_master.sv
// hash_table_master
// Single-outstanding initiator for a hash table op port. Accepts a
// command (valid/ready), issues a one-cycle op_en with registered
// operands, waits for op_done and returns status/value/collision count
// on a valid/ready response channel.
// Optional feature: define HT_MASTER_TIMEOUT_EN to abort a WAIT that
// lasts TIMEOUT_CYCLES cycles with status TIMEOUT.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/ready/op/key/value   command channel
//   op_en/sel/key/value            request to the table
//   op_value_out/done/error/collision_count  table completion
//   rsp_valid/ready/status/value/collision_count  response channel
//   busy                           high whenever the FSM is not idle
module hash_table_master
    import hash_table_master_pkg::*;
#(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 32,
    parameter int CNT_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [KEY_WIDTH-1:0]   cmd_key,
    input  logic [VALUE_WIDTH-1:0] cmd_value,
    output logic                   op_en,
    output logic [1:0]             op_sel,
    output logic [KEY_WIDTH-1:0]   op_key,
    output logic [VALUE_WIDTH-1:0] op_value,
    input  logic [VALUE_WIDTH-1:0] op_value_out,
    input  logic                   op_done,
    input  logic                   op_error,
    input  logic [CNT_WIDTH-1:0]   op_collision_count,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_status,
    output logic [VALUE_WIDTH-1:0] rsp_value,
    output logic [CNT_WIDTH-1:0]   rsp_collision_count,
    output logic                   busy
);

    state_e      state;
    rsp_status_e rsp_status_q;
    logic        accept;
    logic        timeout_hit;

    assign accept = (state == S_IDLE) && cmd_valid;

`ifdef HT_MASTER_TIMEOUT_EN
    logic [15:0] tmr_count;
    logic        tmr_expired;

    hash_table_master_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (accept && is_legal_op(cmd_op)),
        .inc     (state == S_WAIT),
        .limit   (16'(TIMEOUT_CYCLES)),
        .count   (tmr_count),
        .expired (tmr_expired)
    );

    assign timeout_hit = (state == S_WAIT) && tmr_expired;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= S_IDLE;
            op_sel              <= 2'b00;
            op_key              <= '0;
            op_value            <= '0;
            rsp_status_q        <= ST_OK;
            rsp_value           <= '0;
            rsp_collision_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_sel   <= cmd_op;
                        op_key   <= cmd_key;
                        op_value <= cmd_value;
                        if (is_legal_op(cmd_op)) begin
                            state <= S_ISSUE;
                        end else begin
                            rsp_status_q        <= ST_BAD_OP;
                            rsp_value           <= '0;
                            rsp_collision_count <= '0;
                            state               <= S_RESP;
                        end
                    end
                end
                // op_done is honoured in ISSUE too, so a zero-latency table
                // skips WAIT entirely. op_done beats a same-cycle timeout.
                S_ISSUE, S_WAIT: begin
                    if (op_done) begin
                        rsp_status_q        <= op_error ? ST_TABLE_ERROR : ST_OK;
                        rsp_value           <= (op_sel == OP_SEARCH && !op_error)
                                               ? op_value_out : '0;
                        rsp_collision_count <= op_collision_count;
                        state               <= S_RESP;
                    end else if (timeout_hit) begin
                        rsp_status_q        <= ST_TIMEOUT;
                        rsp_value           <= '0;
                        rsp_collision_count <= '0;
                        state               <= S_RESP;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_RESP: begin
                    if (rsp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Gated by rst so the command side sees not-ready during reset even
    // though the state register already reads IDLE.
    assign cmd_ready  = (state == S_IDLE) && !rst;
    assign op_en      = (state == S_ISSUE);
    assign rsp_valid  = (state == S_RESP);
    assign busy       = (state != S_IDLE);
    assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_hash_table_master.sv
module tb_hash_table_master;
    import hash_table_master_pkg::*;

    localparam int KW = 32;
    localparam int VW = 32;
    localparam int CW = 2;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [KW-1:0] cmd_key;
    logic [VW-1:0] cmd_value;
    logic          op_en;
    logic [1:0]    op_sel;
    logic [KW-1:0] op_key;
    logic [VW-1:0] op_value;
    logic [VW-1:0] op_value_out;
    logic          op_done, op_error;
    logic [CW-1:0] op_collision_count;
    logic          rsp_valid, rsp_ready;
    logic [1:0]    rsp_status;
    logic [VW-1:0] rsp_value;
    logic [CW-1:0] rsp_collision_count;
    logic          busy;

    typedef struct {
        logic [1:0]    st;
        logic [VW-1:0] val;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hash_table_master #(
        .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_key(cmd_key), .cmd_value(cmd_value),
        .op_en(op_en), .op_sel(op_sel), .op_key(op_key), .op_value(op_value),
        .op_value_out(op_value_out), .op_done(op_done), .op_error(op_error),
        .op_collision_count(op_collision_count),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_value(rsp_value), .rsp_collision_count(rsp_collision_count),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input exp_t e);
        chk({tag, ".valid"},  64'(rsp_valid), 64'd1);
        chk({tag, ".status"}, 64'(rsp_status), 64'(e.st));
        chk({tag, ".value"},  64'(rsp_value), 64'(e.val));
        chk({tag, ".cnt"},    64'(rsp_collision_count), 64'(e.cnt));
    endtask

    // Drives one command and plays the table: op_done is raised done_at
    // cycles after op_en (0 = in the ISSUE cycle, -1 = never). lat is the
    // expected number of cycles from the ISSUE cycle to the first RESP cycle.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [KW-1:0] key,
                         input logic [VW-1:0] val, input int done_at, input logic err,
                         input logic [VW-1:0] vout, input logic [CW-1:0] cnt,
                         input logic [1:0] exp_st, input int lat, input int hold);
        exp_t e;
        exp_t got;
        int   k;
        chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_value = val;
        e.st  = exp_st;
        e.val = (exp_st == ST_OK && op == OP_SEARCH) ? vout : '0;
        e.cnt = (exp_st == ST_OK || exp_st == ST_TABLE_ERROR) ? cnt : '0;
        sb.push_back(e);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0; cmd_key = '1; cmd_value = '1;
        if (op == OP_ILLEGAL) begin
            chk({tag, ".no_op_en"}, 64'(op_en), 64'd0);
            k = lat;
        end else begin
            k = 0;
            while (!rsp_valid && k < 40) begin
                chk({tag, ".op_en"},  64'(op_en), 64'(k == 0));
                chk({tag, ".op_key"}, 64'(op_key), 64'(key));
                chk({tag, ".op_sel"}, 64'(op_sel), 64'(op));
                if (k == 0) chk({tag, ".op_value"}, 64'(op_value), 64'(val));
                if (k == done_at) begin
                    op_done = 1'b1; op_error = err;
                    op_value_out = vout; op_collision_count = cnt;
                end
                @(posedge clk); @(negedge clk);
                op_done = 1'b0; op_error = 1'b1;
                op_value_out = 32'hDEAD_BEEF; op_collision_count = '1;
                k++;
            end
        end
        chk({tag, ".latency"}, 64'(k), 64'(lat));
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd0, 64'd1);
        end else begin
            got = sb.pop_front();
            chk_rsp(tag, got);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); @(negedge clk);
                chk_rsp({tag, ".hold"}, got);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".busy_after"},    64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_key = '0; cmd_value = '0;
        op_value_out = '0; op_done = 1'b0; op_error = 1'b0; op_collision_count = '0;
        rsp_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst.cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst.op_en",     64'(op_en), 64'd0);
        chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst.busy",      64'(busy), 64'd0);
        chk("rst.op_key",    64'(op_key), 64'd0);
        chk("rst.rsp_status", 64'(rsp_status), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst.cmd_ready", 64'(cmd_ready), 64'd1);

        do_op("insert", OP_INSERT, 32'h05, 32'hAA, 3, 1'b0, 32'h0,  2'd1, ST_OK, 4, 0);
        do_op("search", OP_SEARCH, 32'h05, 32'h77, 2, 1'b0, 32'hAA, 2'd1, ST_OK, 3, 4);
        do_op("delete", OP_DELETE, 32'h09, 32'h33, 0, 1'b1, 32'h55, 2'd2, ST_TABLE_ERROR, 1, 0);
        do_op("badop",  OP_ILLEGAL, 32'h11, 32'h22, 0, 1'b0, 32'h0, 2'd0, ST_BAD_OP, 1, 0);
        do_op("search_fast", OP_SEARCH, 32'h0C, 32'h0, 0, 1'b0, 32'h1234, 2'd3, ST_OK, 1, 1);
`ifdef HT_MASTER_TIMEOUT_EN
        do_op("timeout",   OP_SEARCH, 32'h07, 32'h0, -1, 1'b0, 32'h0,  2'd0, ST_TIMEOUT, TMO + 1, 0);
        do_op("done_at_tmo", OP_SEARCH, 32'h07, 32'h0, TMO, 1'b0, 32'hBB, 2'd2, ST_OK, TMO + 1, 0);
`else
        do_op("long_wait", OP_SEARCH, 32'h07, 32'h0, 3 * TMO, 1'b0, 32'hBB, 2'd2, ST_OK, 3 * TMO + 1, 0);
`endif

        // Reset during WAIT: no response for the aborted command.
        cmd_valid = 1'b1; cmd_op = OP_INSERT; cmd_key = 32'h42; cmd_value = 32'h99;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mid.busy_wait", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst.op_en",     64'(op_en), 64'd0);
        chk("mid_rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst.busy",      64'(busy), 64'd0);
        chk("mid_rst.cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_post.cmd_ready", 64'(cmd_ready), 64'd1);
        op_done = 1'b1; op_error = 1'b0;
        @(posedge clk); @(negedge clk);
        op_done = 1'b0;
        chk("late_done.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("late_done.busy",      64'(busy), 64'd0);
        chk("late_done.sb_empty",  64'(sb.size()), 64'd0);

        do_op("after_rst", OP_INSERT, 32'h0A, 32'h0B, 1, 1'b0, 32'h0, 2'd0, ST_OK, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
